// File: rtl/e_result_hex_tx_if.sv
// rtl/e_result_hex_tx_if.sv - byte-wide ASCII output stream between e_result_hex_tx and its sink
// Signals:
//   tx_data   8  ASCII character (driven by master)
//   tx_valid  1  tx_data valid (driven by master)
//   tx_ready  1  sink accepts; transfer when tx_valid & tx_ready (driven by slave)
// Modports: master (transmitter side), slave (sink side).
interface e_result_hex_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/e_result_hex_tx.sv
// rtl/e_result_hex_tx.sv - runs e_calc once per kick and streams its captured result as ASCII hex
// Purpose: pulses calc_start, waits for calc_done, captures calc_result, then emits 4*WORDS hex
//   characters, most-significant word first, over the tx stream. Optional feature macro
//   E_HEX_TX_EOL_EN appends CR (0x0D) and LF (0x0A) after the last digit.
// Parameters: WORDS (16-bit result words, 1..64), UPPER (1: 'A'-'F', 0: 'a'-'f').
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   kick         request one calculation + transmission (acted on only in IDLE)
//   calc_start   one-cycle start pulse to e_calc
//   calc_done    e_calc completion (pulse or level)
//   calc_result  [15:0] x WORDS, index WORDS-1 most significant
//   tx           master side of the ASCII byte stream
//   busy         high whenever not IDLE
//   sent         one-cycle pulse after the final character transfers
module e_result_hex_tx #(
  parameter int WORDS = 32,
  parameter bit UPPER = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    kick,
  output logic                    calc_start,
  input  logic                    calc_done,
  input  logic [15:0]             calc_result [0:WORDS-1],
  e_result_hex_tx_if.master       tx,
  output logic                    busy,
  output logic                    sent
);

  localparam int NCHARS = 4 * WORDS;
  localparam int IW     = $clog2(4 * WORDS + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_SEND, S_EOL} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] char_idx_q, char_idx_d;
  logic [15:0]   buffer_q [0:WORDS-1];
  logic [15:0]   buffer_d [0:WORDS-1];
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          sent_q, sent_d;

  logic [IW-1:0] next_idx;
  logic [IW-1:0] next_word;
  logic [15:0]   next_word_val;
  logic          last_char;
  logic          xfer;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return (UPPER ? 8'h37 : 8'h57) + {4'h0, n};
  endfunction

  function automatic logic [3:0] nibble(input logic [15:0] w, input logic [1:0] pos);
    case (pos)
      2'd0:    return w[15:12];
      2'd1:    return w[11:8];
      2'd2:    return w[7:4];
      default: return w[3:0];
    endcase
  endfunction

  // tx_data is registered, so the character after the current one is prepared here
  // and loaded on the transfer edge.
  always_comb begin
    next_idx      = char_idx_q + IW'(1);
    next_word     = IW'(WORDS - 1) - (next_idx >> 2);
    next_word_val = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (next_word == IW'(w)) next_word_val = buffer_q[w];
    end
    last_char = (char_idx_q == IW'(NCHARS - 1));
    xfer      = tx_valid_q & tx.tx_ready;
  end

  always_comb begin
    state_d    = state_q;
    char_idx_d = char_idx_q;
    buffer_d   = buffer_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    sent_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (kick) state_d = S_START;
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (calc_done) begin
          // First character comes straight from the input since the buffer loads on this edge.
          buffer_d   = calc_result;
          char_idx_d = '0;
          tx_data_d  = hex_ascii(calc_result[WORDS-1][15:12]);
          tx_valid_d = 1'b1;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        if (xfer) begin
          if (last_char) begin
            char_idx_d = '0;
`ifdef E_HEX_TX_EOL_EN
            tx_data_d  = 8'h0D;
            state_d    = S_EOL;
`else
            tx_data_d  = 8'h00;
            tx_valid_d = 1'b0;
            sent_d     = 1'b1;
            state_d    = S_IDLE;
`endif
          end else begin
            char_idx_d = next_idx;
            tx_data_d  = hex_ascii(nibble(next_word_val, next_idx[1:0]));
          end
        end
      end
`ifdef E_HEX_TX_EOL_EN
      S_EOL: begin
        // The character on the wire tells CR from LF; no extra counter needed.
        if (xfer) begin
          if (tx_data_q == 8'h0D) begin
            tx_data_d = 8'h0A;
          end else begin
            tx_data_d  = 8'h00;
            tx_valid_d = 1'b0;
            sent_d     = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      char_idx_q <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      sent_q     <= 1'b0;
      for (int w = 0; w < WORDS; w++) buffer_q[w] <= '0;
    end else begin
      state_q    <= state_d;
      char_idx_q <= char_idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      sent_q     <= sent_d;
      buffer_q   <= buffer_d;
    end
  end

  assign calc_start  = (state_q == S_START);
  assign busy        = (state_q != S_IDLE);
  assign sent        = sent_q;
  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;

endmodule
